decode_stage_hz: RTL and testbench

- Parametrised successor of the ID stage of the 5-stage MIPS pipeline.
- Decodes IF/ID instruction, reads the architectural register file, and applies the WB write and same-cycle WB bypass.
- Adds features the previous decode stage lacked: sign-extended immediate, hardwired R0, load-use hazard detection with bubble insertion, branch flush, valid tracking, and a saturating hazard counter.
- Sits between fetch (IF/ID register) and execute (ID/EX register).

---
 rtl/decode_stage_hz_pkg.sv | 36 +++
 rtl/decode_stage_hz_if.sv | 35 +++
 rtl/decode_stage_hz_regfile_bypass.sv | 37 +++
 rtl/decode_stage_hz.sv | 113 +++++++++++
 tb/tb_decode_stage_hz.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_hz_pkg.sv
// Shared MIPS decode definitions: opcodes, instruction classes, the ID/EX bubble and decode helpers.
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        T_NOP = 2'b00,
        T_J   = 2'b01,
        T_I   = 2'b10,
        T_R   = 2'b11
    } instr_type_e;

    typedef struct packed {
        logic        valid;
        instr_type_e itype;
        logic [5:0]  op;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t BUBBLE_CTRL = '{valid: 1'b0, itype: T_NOP, op: 6'd0};

    // An all-zero R-format word is the canonical NOP, so it must not classify as R.
    function automatic instr_type_e classify(input logic [31:0] ir);
        if (ir[31:26] == 6'd0 && ir[25:0] != 26'd0) return T_R;
        else if (ir[31:28] != 4'd0)                 return T_I;
        else if (ir[27])                            return T_J;
        else                                        return T_NOP;
    endfunction

    function automatic logic uses_rt(input logic [5:0] opcode, input instr_type_e t);
        return (t == T_R) || (opcode == OP_SW) || (opcode == OP_BEQ) || (opcode == OP_BNE);
    endfunction

endpackage

// File: rtl/decode_stage_hz_if.sv
// IF/ID inputs and ID/EX outputs of the decode stage, grouped as one pipeline bundle.
interface decode_stage_hz_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
);
    // Each side is qualified only by its valid bit; there is no ready. Back-pressure is
    // id_stall_c toward fetch and the ex/mem stall inputs toward this stage.
    logic              IF_ID_valid;
    logic [ADDR_W-1:0] IF_ID_nextPC;
    logic [31:0]       IF_ID_IR;

    logic              ID_EX_valid;
    logic [ADDR_W-1:0] ID_EX_nextPC;
    logic [DATA_W-1:0] ID_EX_A;
    logic [DATA_W-1:0] ID_EX_B;
    logic [DATA_W-1:0] ID_EX_imm;
    logic [REG_W-1:0]  ID_EX_rs;
    logic [REG_W-1:0]  ID_EX_rt;
    logic [REG_W-1:0]  ID_EX_rd;
    logic [5:0]        ID_EX_op;
    logic [1:0]        ID_EX_instruc_type;

    modport master (
        input  IF_ID_valid, IF_ID_nextPC, IF_ID_IR,
        output ID_EX_valid, ID_EX_nextPC, ID_EX_A, ID_EX_B, ID_EX_imm,
               ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_op, ID_EX_instruc_type
    );

    modport slave (
        output IF_ID_valid, IF_ID_nextPC, IF_ID_IR,
        input  ID_EX_valid, ID_EX_nextPC, ID_EX_A, ID_EX_B, ID_EX_imm,
               ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_op, ID_EX_instruc_type
    );
endinterface

// File: rtl/decode_stage_hz_regfile_bypass.sv
// Architectural register file: two read ports, one write port, R0 hardwired to zero,
// and a same-cycle bypass from the writeback port.
module regfile_bypass #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_W    = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic [REG_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_W-1:0]  rd_idx_a,
    input  logic [REG_W-1:0]  rd_idx_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);
    logic [DATA_W-1:0] rf [NUM_REGS];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (we && wr_idx != '0) begin
            rf[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = '0;
        if (rd_idx_a != '0) rd_data_a = (we && wr_idx == rd_idx_a) ? wr_data : rf[rd_idx_a];
    end

    always_comb begin
        rd_data_b = '0;
        if (rd_idx_b != '0) rd_data_b = (we && wr_idx == rd_idx_b) ? wr_data : rf[rd_idx_b];
    end
endmodule

// File: rtl/decode_stage_hz.sv
// MIPS ID stage: decode, register read with WB bypass, load-use interlock and the ID/EX register.
module decode_stage_hz
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_W    = $clog2(NUM_REGS),
    parameter int CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_stall_c,
    input  logic              mem_stall_c,
    input  logic              flush_c,
    input  logic              WB_WEenable,
    input  logic [REG_W-1:0]  WB_dest,
    input  logic [DATA_W-1:0] WB_value,
    decode_stage_hz_if.master pipe,
    output logic              id_stall_c,
    output logic [CNT_W-1:0]  hazard_count
);
    logic [31:0]       ir;
    logic [5:0]        opcode;
    logic [REG_W-1:0]  rs, rt, rd;
    logic [DATA_W-1:0] imm, rd_a, rd_b;
    instr_type_e       itype;
    logic [5:0]        op_dec;
    logic              hazard, down_stall;

    id_ex_ctrl_t       ctrl_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] a_q, b_q, imm_q;
    logic [REG_W-1:0]  rs_q, rt_q, rd_q;
    logic [CNT_W-1:0]  cnt_q;

    assign ir     = pipe.IF_ID_IR;
    assign opcode = ir[31:26];
    assign rs     = ir[21 +: REG_W];
    assign rt     = ir[16 +: REG_W];
    assign rd     = ir[11 +: REG_W];
    assign imm    = {{(DATA_W-16){ir[15]}}, ir[15:0]};
    assign itype  = classify(ir);
    assign op_dec = (itype == T_R) ? ir[5:0] : opcode;

    regfile_bypass #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_rf (
        .clock     (clock),
        .reset_n   (reset_n),
        .we        (WB_WEenable),
        .wr_idx    (WB_dest),
        .wr_data   (WB_value),
        .rd_idx_a  (rs),
        .rd_idx_b  (rt),
        .rd_data_a (rd_a),
        .rd_data_b (rd_b)
    );

    // A load in EX whose destination feeds this instruction needs one bubble;
    // the bubble clears ctrl_q.valid, so the hazard drops by itself next cycle.
    assign hazard = ctrl_q.valid && ctrl_q.itype == T_I && ctrl_q.op == OP_LW && rt_q != '0
                    && pipe.IF_ID_valid
                    && (rt_q == rs || (uses_rt(opcode, itype) && rt_q == rt));

    assign down_stall = ex_stall_c | mem_stall_c;
    assign id_stall_c = down_stall | (hazard & ~flush_c);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ctrl_q <= BUBBLE_CTRL;
            pc_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            imm_q  <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
        end else if (down_stall) begin
            ctrl_q <= ctrl_q;
        end else if (flush_c || hazard) begin
            ctrl_q <= BUBBLE_CTRL;
            pc_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            imm_q  <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
            if (!flush_c && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end else begin
            ctrl_q <= '{valid: pipe.IF_ID_valid, itype: itype, op: op_dec};
            pc_q   <= pipe.IF_ID_nextPC;
            a_q    <= rd_a;
            b_q    <= rd_b;
            imm_q  <= imm;
            rs_q   <= rs;
            rt_q   <= rt;
            rd_q   <= rd;
        end
    end

    assign pipe.ID_EX_valid        = ctrl_q.valid;
    assign pipe.ID_EX_instruc_type = ctrl_q.itype;
    assign pipe.ID_EX_op           = ctrl_q.op;
    assign pipe.ID_EX_nextPC       = pc_q;
    assign pipe.ID_EX_A            = a_q;
    assign pipe.ID_EX_B            = b_q;
    assign pipe.ID_EX_imm          = imm_q;
    assign pipe.ID_EX_rs           = rs_q;
    assign pipe.ID_EX_rt           = rt_q;
    assign pipe.ID_EX_rd           = rd_q;
    assign hazard_count            = cnt_q;
endmodule

// File: tb/tb_decode_stage_hz.sv
// Bench for decode_stage_hz: scenario tasks drive IF/ID and WB, expected ID/EX words are
// queued per cycle and compared at the negedge after the register captures them.
module tb_decode_stage_hz;
    import mips_pkg::*;

    localparam int EXP_W = 1 + 2 + 6 + 32 * 3 + 5 * 3 + 32;

    logic        clock;
    logic        reset_n;
    logic        ex_stall_c, mem_stall_c, flush_c;
    logic        WB_WEenable;
    logic [4:0]  WB_dest;
    logic [31:0] WB_value;
    logic        id_stall_c;
    logic [15:0] hazard_count;

    decode_stage_hz_if pipe ();

    decode_stage_hz dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ex_stall_c   (ex_stall_c),
        .mem_stall_c  (mem_stall_c),
        .flush_c      (flush_c),
        .WB_WEenable  (WB_WEenable),
        .WB_dest      (WB_dest),
        .WB_value     (WB_value),
        .pipe         (pipe),
        .id_stall_c   (id_stall_c),
        .hazard_count (hazard_count)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [EXP_W-1:0] exp_q[$];
    int               exp_cyc_q[$];
    logic [EXP_W-1:0] got_vec;

    assign got_vec = {pipe.ID_EX_valid, pipe.ID_EX_instruc_type, pipe.ID_EX_op,
                      pipe.ID_EX_A, pipe.ID_EX_B, pipe.ID_EX_imm,
                      pipe.ID_EX_rs, pipe.ID_EX_rt, pipe.ID_EX_rd, pipe.ID_EX_nextPC};

    always @(posedge clock) cyc <= cyc + 1;

    // scoreboard: each entry becomes due on the cycle after it was queued
    always @(negedge clock) begin
        if (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            logic [EXP_W-1:0] e;
            e = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
            n_checks++;
            if (got_vec !== e) $display("FAIL id_ex cyc=%0d got=%h exp=%h", cyc, got_vec, e);
            else n_pass++;
        end
    end

    function automatic logic [EXP_W-1:0] pk(input logic v, input logic [1:0] t, input logic [5:0] op,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] imm, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [31:0] pc);
        return {v, t, op, a, b, imm, rs, rt, rd, pc};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'd0, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_if(input logic v, input logic [31:0] ir, input logic [31:0] pc);
        pipe.IF_ID_valid  = v;
        pipe.IF_ID_IR     = ir;
        pipe.IF_ID_nextPC = pc;
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] d, input logic [31:0] val);
        WB_WEenable = we;
        WB_dest     = d;
        WB_value    = val;
    endtask

    task automatic push_exp(input logic [EXP_W-1:0] e);
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ex_stall_c = 1'b0; mem_stall_c = 1'b0; flush_c = 1'b0;
        drive_wb(1'b1, 5'd5, 32'hDEAD);
        drive_if(1'b1, enc_r(5'd5, 5'd0, 5'd3, 6'h20), 32'h100);
        push_exp('0);
        tick();
        push_exp('0);
        tick();
        n_checks++;
        if (hazard_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", hazard_count);
        else n_pass++;
        n_checks++;
        if (id_stall_c !== 1'b0) $display("FAIL reset_stall got=%b exp=0", id_stall_c);
        else n_pass++;
        // R5 written only during reset must still read zero
        reset_n = 1'b1;
        drive_wb(1'b0, 5'd0, 32'h0);
        push_exp(pk(1'b1, 2'b11, 6'h20, 32'h0, 32'h0, 32'h1820, 5'd5, 5'd0, 5'd3, 32'h100));
        tick();
    endtask

    task automatic test_wb_decode();
        drive_wb(1'b1, 5'd5, 32'h1234);
        drive_if(1'b0, 32'h0, 32'h0);
        push_exp('0);
        tick();
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_if(1'b1, enc_r(5'd5, 5'd0, 5'd3, 6'h20), 32'h104);
        push_exp(pk(1'b1, 2'b11, 6'h20, 32'h1234, 32'h0, 32'h1820, 5'd5, 5'd0, 5'd3, 32'h104));
        tick();
        n_checks++;
        if (pipe.ID_EX_A !== 32'h1234) $display("FAIL add_operand_a got=%h exp=00001234", pipe.ID_EX_A);
        else n_pass++;
    endtask

    task automatic test_bypass();
        drive_wb(1'b1, 5'd7, 32'hBEEF);
        drive_if(1'b1, enc_r(5'd7, 5'd0, 5'd1, 6'h20), 32'h108);
        push_exp(pk(1'b1, 2'b11, 6'h20, 32'hBEEF, 32'h0, 32'h0820, 5'd7, 5'd0, 5'd1, 32'h108));
        tick();
        drive_wb(1'b1, 5'd0, 32'hFFFF);
        drive_if(1'b1, enc_r(5'd0, 5'd0, 5'd2, 6'h20), 32'h10C);
        push_exp(pk(1'b1, 2'b11, 6'h20, 32'h0, 32'h0, 32'h1020, 5'd0, 5'd0, 5'd2, 32'h10C));
        tick();
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_if(1'b1, enc_r(5'd0, 5'd7, 5'd4, 6'h20), 32'h110);
        push_exp(pk(1'b1, 2'b11, 6'h20, 32'h0, 32'hBEEF, 32'h2020, 5'd0, 5'd7, 5'd4, 32'h110));
        tick();
    endtask

    task automatic test_load_use();
        drive_if(1'b1, enc_i(OP_LW, 5'd5, 5'd8, 16'h0004), 32'h200);
        #1;
        n_checks++;
        if (id_stall_c !== 1'b0) $display("FAIL lw_issue_stall got=%b exp=0", id_stall_c);
        else n_pass++;
        push_exp(pk(1'b1, 2'b10, 6'h23, 32'h1234, 32'h0, 32'h4, 5'd5, 5'd8, 5'd0, 32'h200));
        tick();
        drive_wb(1'b1, 5'd8, 32'h55);
        drive_if(1'b1, enc_r(5'd8, 5'd0, 5'd9, 6'h20), 32'h204);
        #1;
        n_checks++;
        if (id_stall_c !== 1'b1) $display("FAIL load_use_stall got=%b exp=1", id_stall_c);
        else n_pass++;
        push_exp('0);
        tick();
        n_checks++;
        if (hazard_count !== 16'd1) $display("FAIL load_use_count got=%0d exp=1", hazard_count);
        else n_pass++;
        drive_wb(1'b0, 5'd0, 32'h0);
        #1;
        n_checks++;
        if (id_stall_c !== 1'b0) $display("FAIL load_use_release got=%b exp=0", id_stall_c);
        else n_pass++;
        push_exp(pk(1'b1, 2'b11, 6'h20, 32'h55, 32'h0, 32'h4820, 5'd8, 5'd0, 5'd9, 32'h204));
        tick();
    endtask

    task automatic test_no_hazard_ori();
        drive_if(1'b1, enc_i(OP_LW, 5'd0, 5'd8, 16'h0000), 32'h300);
        push_exp(pk(1'b1, 2'b10, 6'h23, 32'h0, 32'h55, 32'h0, 5'd0, 5'd8, 5'd0, 32'h300));
        tick();
        drive_if(1'b1, enc_i(6'b001101, 5'd2, 5'd8, 16'h00FF), 32'h304);
        #1;
        n_checks++;
        if (id_stall_c !== 1'b0) $display("FAIL ori_stall got=%b exp=0", id_stall_c);
        else n_pass++;
        push_exp(pk(1'b1, 2'b10, 6'h0D, 32'h0, 32'h55, 32'hFF, 5'd2, 5'd8, 5'd0, 32'h304));
        tick();
        n_checks++;
        if (hazard_count !== 16'd1) $display("FAIL ori_count got=%0d exp=1", hazard_count);
        else n_pass++;
    endtask

    task automatic test_flush_hazard();
        drive_if(1'b1, enc_i(OP_LW, 5'd0, 5'd8, 16'h0000), 32'h400);
        push_exp(pk(1'b1, 2'b10, 6'h23, 32'h0, 32'h55, 32'h0, 5'd0, 5'd8, 5'd0, 32'h400));
        tick();
        flush_c = 1'b1;
        drive_if(1'b1, enc_i(OP_SW, 5'd0, 5'd8, 16'h0008), 32'h404);
        #1;
        n_checks++;
        if (id_stall_c !== 1'b0) $display("FAIL flush_stall got=%b exp=0", id_stall_c);
        else n_pass++;
        push_exp('0);
        tick();
        flush_c = 1'b0;
        n_checks++;
        if (hazard_count !== 16'd1) $display("FAIL flush_count got=%0d exp=1", hazard_count);
        else n_pass++;
    endtask

    task automatic test_mem_stall();
        logic [EXP_W-1:0] held;
        held = pk(1'b1, 2'b10, 6'h08, 32'hBEEF, 32'h0, 32'h5, 5'd7, 5'd10, 5'd0, 32'h500);
        drive_if(1'b1, enc_i(6'b001000, 5'd7, 5'd10, 16'h0005), 32'h500);
        push_exp(held);
        tick();
        mem_stall_c = 1'b1;
        drive_if(1'b1, enc_r(5'd11, 5'd12, 5'd13, 6'h20), 32'h504);
        for (int i = 0; i < 3; i++) begin
            drive_wb(1'b1, 5'(11 + i), 32'h1111 * (i + 1));
            #1;
            n_checks++;
            if (id_stall_c !== 1'b1) $display("FAIL mem_stall_out[%0d] got=%b exp=1", i, id_stall_c);
            else n_pass++;
            push_exp(held);
            tick();
        end
        mem_stall_c = 1'b0;
        drive_wb(1'b0, 5'd0, 32'h0);
        push_exp(pk(1'b1, 2'b11, 6'h20, 32'h1111, 32'h2222, 32'h6820, 5'd11, 5'd12, 5'd13, 32'h504));
        tick();
        drive_if(1'b1, enc_r(5'd13, 5'd0, 5'd1, 6'h20), 32'h508);
        push_exp(pk(1'b1, 2'b11, 6'h20, 32'h3333, 32'h0, 32'h0820, 5'd13, 5'd0, 5'd1, 32'h508));
        tick();
    endtask

    task automatic test_stall_with_hazard();
        logic [EXP_W-1:0] lw_e;
        lw_e = pk(1'b1, 2'b10, 6'h23, 32'h0, 32'h55, 32'h0, 5'd0, 5'd8, 5'd0, 32'h600);
        drive_if(1'b1, enc_i(OP_LW, 5'd0, 5'd8, 16'h0000), 32'h600);
        push_exp(lw_e);
        tick();
        ex_stall_c = 1'b1;
        drive_if(1'b1, enc_r(5'd8, 5'd0, 5'd9, 6'h20), 32'h604);
        for (int i = 0; i < 2; i++) begin
            push_exp(lw_e);
            tick();
            n_checks++;
            if (hazard_count !== 16'd1) $display("FAIL stalled_count[%0d] got=%0d exp=1", i, hazard_count);
            else n_pass++;
        end
        ex_stall_c = 1'b0;
        #1;
        n_checks++;
        if (id_stall_c !== 1'b1) $display("FAIL post_stall_hazard got=%b exp=1", id_stall_c);
        else n_pass++;
        push_exp('0);
        tick();
        n_checks++;
        if (hazard_count !== 16'd2) $display("FAIL post_stall_count got=%0d exp=2", hazard_count);
        else n_pass++;
        push_exp(pk(1'b1, 2'b11, 6'h20, 32'h55, 32'h0, 32'h4820, 5'd8, 5'd0, 5'd9, 32'h604));
        tick();
    endtask

    task automatic test_invalid_and_types();
        drive_if(1'b1, enc_i(OP_LW, 5'd0, 5'd8, 16'h0000), 32'h700);
        push_exp(pk(1'b1, 2'b10, 6'h23, 32'h0, 32'h55, 32'h0, 5'd0, 5'd8, 5'd0, 32'h700));
        tick();
        drive_if(1'b0, enc_r(5'd8, 5'd0, 5'd9, 6'h20), 32'h704);
        #1;
        n_checks++;
        if (id_stall_c !== 1'b0) $display("FAIL invalid_no_stall got=%b exp=0", id_stall_c);
        else n_pass++;
        push_exp(pk(1'b0, 2'b11, 6'h20, 32'h55, 32'h0, 32'h4820, 5'd8, 5'd0, 5'd9, 32'h704));
        tick();
        n_checks++;
        if (hazard_count !== 16'd2) $display("FAIL invalid_count got=%0d exp=2", hazard_count);
        else n_pass++;
        drive_if(1'b1, enc_i(6'b001000, 5'd0, 5'd1, 16'h8001), 32'h708);
        push_exp(pk(1'b1, 2'b10, 6'h08, 32'h0, 32'h0, 32'hFFFF8001, 5'd0, 5'd1, 5'd16, 32'h708));
        tick();
        n_checks++;
        if (pipe.ID_EX_imm !== 32'hFFFF8001) $display("FAIL addi_imm got=%h exp=ffff8001", pipe.ID_EX_imm);
        else n_pass++;
        drive_if(1'b1, 32'h0800_0010, 32'h70C);
        push_exp(pk(1'b1, 2'b01, 6'h02, 32'h0, 32'h0, 32'h10, 5'd0, 5'd0, 5'd0, 32'h70C));
        tick();
        drive_if(1'b1, 32'h0, 32'h710);
        push_exp(pk(1'b1, 2'b00, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h710));
        tick();
        drive_if(1'b1, enc_i(6'b000001, 5'd3, 5'd1, 16'h0010), 32'h714);
        push_exp(pk(1'b1, 2'b00, 6'h01, 32'h0, 32'h0, 32'h10, 5'd3, 5'd1, 5'd0, 32'h714));
        tick();
    endtask

    initial begin
        test_reset();
        test_wb_decode();
        test_bypass();
        test_load_use();
        test_no_hazard_ori();
        test_flush_hazard();
        test_mem_stall();
        test_stall_with_hazard();
        test_invalid_and_types();
        drive_if(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
